dem_switch_seq_gen: RTL and testbench

Generates, per switching node of the DEM-DAC tree, the pseudorandom swap bit and the first-order noise-shaped switching sequence value consumed by each switching block's `pn_seq_i` and `quantized_value_i`. It sits directly upstream of the switching-block tree and serves all nodes from one shared LFSR and one per-node shaping state. Switching sequences are produced combinationally from registered state, so they align with the node inputs of the same cycle.

---
 rtl/lib_switchblock_pkg.sv | 12 +
 rtl/dem_shape_node.sv | 44 ++++
 rtl/dem_switch_seq_gen.sv | 76 +++++++
 tb/tb_dem_switch_seq_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lib_switchblock_pkg.sv
// Shared constants and types for the DEM-DAC switching-block tree and its
// sequence generator.
package lib_switchblock_pkg;
   localparam int                  LFSR_LEN = 31;
   localparam logic [LFSR_LEN-1:0] SEED     = 31'h0000_0001;
   localparam int                  TAP_HI   = 30;
   localparam int                  TAP_LO   = 27;
   localparam int                  SEQ_W    = 16;

   typedef logic signed [SEQ_W-1:0] seq_t;
   typedef logic signed [1:0]       acc_t;
endpackage

// File: rtl/dem_shape_node.sv
// One switching node: first-order noise-shaping accumulator and the
// combinational switching-sequence selection that feeds it.
module dem_shape_node
   import lib_switchblock_pkg::*;
#(
   parameter int WIDTH = SEQ_W
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    adv_i,
   input  logic                    parity_i,
   input  logic                    pn_i,
   output logic signed [WIDTH-1:0] s_o,
   output acc_t                    acc_o
);

   acc_t              acc_q, acc_d;
   acc_t              s_sel;
   logic signed [2:0] sum;

   always_comb begin
      s_sel = '0;
      if (parity_i) begin
         // Drive the accumulator back toward zero; the pn bit breaks the tie.
         if (acc_q > 0)      s_sel = 2'sb11;
         else if (acc_q < 0) s_sel = 2'sb01;
         else                s_sel = pn_i ? 2'sb01 : 2'sb11;
      end
      sum   = {acc_q[1], acc_q} + {s_sel[1], s_sel};
      acc_d = adv_i ? sum[1:0] : acc_q;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) acc_q <= '0;
      else         acc_q <= acc_d;
   end

   assign s_o   = reset_i ? '0 : {{(WIDTH-2){s_sel[1]}}, s_sel};
   assign acc_o = acc_q;

   a_acc_range: assert property (@(posedge clk_i) disable iff (reset_i)
      adv_i |-> (sum >= -3'sd1 && sum <= 3'sd1));

endmodule

// File: rtl/dem_switch_seq_gen.sv
// Per-node pseudorandom swap bits and noise-shaped switching sequences for the
// DEM-DAC tree, from one shared multi-step LFSR.
module dem_switch_seq_gen #(
   parameter int                  WIDTH     = 16,
   parameter int                  NUM_NODES = 7,
   parameter int                  LFSR_LEN  = lib_switchblock_pkg::LFSR_LEN,
   parameter logic [LFSR_LEN-1:0] SEED      = lib_switchblock_pkg::SEED
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         en_i,
   input  logic                         seed_load_i,
   input  logic [LFSR_LEN-1:0]          seed_i,
   input  logic [NUM_NODES-1:0]         parity_i,
   output logic [NUM_NODES-1:0]         pn_o,
   output logic [NUM_NODES*WIDTH-1:0]   s_o,
   output logic [NUM_NODES*2-1:0]       acc_o
);

   logic [LFSR_LEN-1:0]  lfsr_q, lfsr_d, lfsr_adv;
   logic [NUM_NODES-1:0] pn_q, pn_d, pn_adv;
   logic                 adv;

   assign adv = en_i & ~seed_load_i;

   always_comb begin
      logic [LFSR_LEN-1:0] st;
      st     = lfsr_q;
      pn_adv = '0;
      // NUM_NODES Fibonacci steps per enable; each node takes one feedback bit.
      for (int k = 0; k < NUM_NODES; k++) begin
         pn_adv[k] = st[lib_switchblock_pkg::TAP_HI] ^ st[lib_switchblock_pkg::TAP_LO];
         st        = {st[LFSR_LEN-2:0], pn_adv[k]};
      end
      lfsr_adv = st;

      lfsr_d = lfsr_q;
      pn_d   = pn_q;
      if (seed_load_i) begin
         lfsr_d = (seed_i == '0) ? SEED : seed_i;
      end else if (en_i) begin
         lfsr_d = lfsr_adv;
         pn_d   = pn_adv;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         lfsr_q <= SEED;
         pn_q   <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         pn_q   <= pn_d;
      end
   end

   assign pn_o = pn_q;

   for (genvar k = 0; k < NUM_NODES; k++) begin : g_node
      dem_shape_node #(
         .WIDTH(WIDTH)
      ) u_node (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .adv_i   (adv),
         .parity_i(parity_i[k]),
         .pn_i    (pn_q[k]),
         .s_o     (s_o[k*WIDTH +: WIDTH]),
         .acc_o   (acc_o[k*2 +: 2])
      );
   end

   a_lfsr_nonzero: assert property (@(posedge clk_i) disable iff (reset_i)
      lfsr_q != '0);

endmodule

// File: tb/tb_dem_switch_seq_gen.sv
// Bench for dem_switch_seq_gen: directed vector table, corner sequences and a
// long randomized run against a behavioural model.
module tb_dem_switch_seq_gen;
   localparam int N = 7;
   localparam int W = 16;
   localparam bit [30:0] SEED_V = 31'h1;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           en = 1'b0;
   logic           load = 1'b0;
   logic [30:0]    seed = '0;
   logic [N-1:0]   parity = '0;
   logic [N-1:0]   pn;
   logic [N*W-1:0] s;
   logic [2*N-1:0] acc;

   int checks = 0;
   int errors = 0;

   bit [30:0] m_lfsr = SEED_V;
   bit [N-1:0] m_pn = '0;
   int m_acc[N];

   always #5 clk = ~clk;

   dem_switch_seq_gen dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .en_i       (en),
      .seed_load_i(load),
      .seed_i     (seed),
      .parity_i   (parity),
      .pn_o       (pn),
      .s_o        (s),
      .acc_o      (acc)
   );

   typedef struct {
      bit        en;
      bit        load;
      bit [30:0] seed;
      bit [N-1:0] par;
      int        exp_s;
      bit        chk_st;
      bit [30:0] exp_lfsr;
      int        exp_acc;
   } vec_t;

   vec_t tbl[7];

   function void check(string nm, logic signed [63:0] act, logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endfunction

   function int s_word(int k);
      return int'($signed(s[k*W +: W]));
   endfunction

   function int acc_word(int k);
      return int'($signed(acc[2*k +: 2]));
   endfunction

   function int model_s(int k, bit par);
      if (!par) return 0;
      if (m_acc[k] > 0) return -1;
      if (m_acc[k] < 0) return 1;
      return m_pn[k] ? 1 : -1;
   endfunction

   function void model_reset();
      m_lfsr = SEED_V;
      m_pn   = '0;
      for (int k = 0; k < N; k++) m_acc[k] = 0;
   endfunction

   function void model_clock();
      int fb;
      if (load) begin
         m_lfsr = (seed == 0) ? SEED_V : seed;
      end else if (en) begin
         for (int k = 0; k < N; k++) m_acc[k] = m_acc[k] + model_s(k, parity[k]);
         for (int k = 0; k < N; k++) begin
            fb      = int'(((m_lfsr >> 30) ^ (m_lfsr >> 27)) & 31'h1);
            m_pn[k] = fb[0];
            m_lfsr  = (m_lfsr << 1) | 31'(fb);
         end
      end
   endfunction

   task automatic check_comb();
      for (int k = 0; k < N; k++) check($sformatf("s%0d", k), s_word(k), model_s(k, parity[k]));
   endtask

   task automatic check_state();
      check("lfsr", dut.lfsr_q, m_lfsr);
      check("pn", pn, m_pn);
      for (int k = 0; k < N; k++) begin
         check($sformatf("acc%0d", k), acc_word(k), m_acc[k]);
         if (m_acc[k] < -1 || m_acc[k] > 1) check("acc_range", m_acc[k], 0);
      end
   endtask

   task automatic step(bit e, bit l, bit [30:0] sd, bit [N-1:0] p);
      @(negedge clk);
      en = e; load = l; seed = sd; parity = p;
      #1 check_comb();
      @(posedge clk);
      model_clock();
      #1 check_state();
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 31'h0,         7'h00, 0,  1'b1, 31'h0000_0080, 0};
      tbl[1] = '{1'b1, 1'b0, 31'h0,         7'h7F, -1, 1'b1, 31'h0000_4000, -1};
      tbl[2] = '{1'b1, 1'b0, 31'h0,         7'h7F, 1,  1'b1, 31'h0020_0000, 0};
      tbl[3] = '{1'b0, 1'b0, 31'h0,         7'h7F, -1, 1'b1, 31'h0020_0000, 0};
      tbl[4] = '{1'b0, 1'b1, 31'h0,         7'h7F, -1, 1'b1, 31'h0000_0001, 0};
      tbl[5] = '{1'b1, 1'b1, 31'h5A5A_5A5A, 7'h7F, -1, 1'b1, 31'h5A5A_5A5A, 0};
      tbl[6] = '{1'b1, 1'b0, 31'h0,         7'h7F, -1, 1'b0, 31'h0,         -1};

      model_reset();
      parity = 7'h7F;
      #12;
      check("rst_lfsr", dut.lfsr_q, 31'h1);
      check("rst_pn", pn, 0);
      check("rst_acc", acc, 0);
      check("rst_s", s, 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         en = tbl[i].en; load = tbl[i].load; seed = tbl[i].seed; parity = tbl[i].par;
         #1;
         for (int k = 0; k < N; k++) check($sformatf("tbl%0d_s%0d", i, k), s_word(k), tbl[i].exp_s);
         @(posedge clk);
         model_clock();
         #1;
         if (tbl[i].chk_st) begin
            check($sformatf("tbl%0d_lfsr", i), dut.lfsr_q, tbl[i].exp_lfsr);
            check($sformatf("tbl%0d_pn", i), pn, 0);
         end
         for (int k = 0; k < N; k++) check($sformatf("tbl%0d_acc%0d", i, k), acc_word(k), tbl[i].exp_acc);
      end

      // Zero parity: no shaping activity, accumulators stay at -1.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 31'h0, 7'h00);
         check("zero_par_s", s, 0);
         check("zero_par_acc", acc, 14'h3FFF);
      end

      // Asynchronous reset mid-stream with acc = -1.
      @(negedge clk);
      en = 1'b1; parity = 7'h7F;
      #2 reset = 1'b1;
      #1;
      check("async_acc", acc, 0);
      check("async_pn", pn, 0);
      check("async_s", s, 0);
      check("async_lfsr", dut.lfsr_q, 31'h1);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      en = 1'b0;

      for (int i = 0; i < 65536; i++) begin
         bit e, l;
         bit [30:0] sd;
         e  = ($urandom_range(0, 3) != 0);
         l  = ($urandom_range(0, 63) == 0);
         sd = ($urandom_range(0, 3) == 0) ? 31'h0 : 31'($urandom);
         step(e, l, sd, 7'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
